// File: rtl/cpu_clken_gen.sv
// Multi-channel fractional clock-enable generator with run/halt/step/burst control
// and a PLL-lock driven reset sequencer for the CPU domain.
module cpu_clken_gen #(
  parameter int          NUM_CH      = 2,
  parameter int          ACC_W       = 24,
  parameter int          BURST_W     = 16,
  parameter int unsigned GATED_MASK  = 1,
  parameter int          SYNC_STAGES = 3,
  parameter int          RESET_DELAY = 16,
  parameter int          START_RUN   = 1
) (
  input  logic                    clk_cpu_fast,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*ACC_W-1:0] ch_inc,
  input  logic                    cmd_valid,
  input  logic [1:0]              cmd_mode,
  input  logic [BURST_W-1:0]      cmd_count,
  output logic                    cmd_ready,
  output logic [NUM_CH-1:0]       clk_en,
  output logic                    rst_cpu_n,
  output logic                    done,
  output logic [2:0]              run_state
);

  typedef enum logic [2:0] {
    RESET_WAIT = 3'd0,
    HALT       = 3'd1,
    RUN        = 3'd2,
    STEP       = 3'd3,
    BURST      = 3'd4
  } run_state_e;

  localparam int DLY_W = $clog2(RESET_DELAY + 1);
  localparam logic [NUM_CH-1:0] GATED = GATED_MASK[NUM_CH-1:0];

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  run_state_e             state_q, state_d;
  logic [BURST_W-1:0]     rem_q, rem_d;
  logic [ACC_W-1:0]       acc_q [NUM_CH];
  logic [ACC_W-1:0]       acc_d [NUM_CH];
  logic [NUM_CH-1:0]      clk_en_q, clk_en_d;
  logic                   done_q, done_d;
  logic                   rst_cpu_n_q, rst_cpu_n_d;
  logic [ACC_W:0]         sum;
  logic                   sync_out;
  logic                   adv_gated, adv_all, cmd_fire;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign cmd_ready = (state_q != RESET_WAIT);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign adv_all   = (state_q != RESET_WAIT);
  assign adv_gated = (state_q == RUN) || (state_q == STEP) || (state_q == BURST);

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], pll_locked};
    dly_d       = dly_q;
    state_d     = state_q;
    rem_d       = rem_q;
    acc_d       = acc_q;
    clk_en_d    = '0;
    done_d      = 1'b0;
    rst_cpu_n_d = rst_cpu_n_q;
    sum         = '0;

    if (!sync_out) begin
      // Lost lock overrides everything, including a pending command.
      dly_d       = '0;
      state_d     = RESET_WAIT;
      rem_d       = '0;
      rst_cpu_n_d = 1'b0;
      for (int i = 0; i < NUM_CH; i++) acc_d[i] = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (GATED[i] ? adv_gated : adv_all) begin
          sum         = {1'b0, acc_q[i]} + {1'b0, ch_inc[i*ACC_W +: ACC_W]};
          acc_d[i]    = sum[ACC_W-1:0];
          clk_en_d[i] = sum[ACC_W];
        end
      end

      if (state_q == RESET_WAIT) begin
        if (dly_q == DLY_W'(RESET_DELAY - 1)) begin
          state_d     = (START_RUN != 0) ? RUN : HALT;
          rst_cpu_n_d = 1'b1;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end else begin
        // The final master carry still emits its pulse; a same-edge command wins the state.
        if (((state_q == STEP) || (state_q == BURST)) && clk_en_d[0]) begin
          if (rem_q == BURST_W'(1)) begin
            done_d  = 1'b1;
            state_d = HALT;
          end else begin
            rem_d = rem_q - BURST_W'(1);
          end
        end
        if (cmd_fire) begin
          case (cmd_mode)
            2'b00: state_d = RUN;
            2'b01: state_d = HALT;
            2'b10: begin
              state_d = STEP;
              rem_d   = BURST_W'(1);
            end
            default: begin
              if (cmd_count == '0) begin
                state_d = HALT;
                done_d  = 1'b1;
              end else begin
                state_d = BURST;
                rem_d   = cmd_count;
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_cpu_fast or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      dly_q       <= '0;
      state_q     <= RESET_WAIT;
      rem_q       <= '0;
      clk_en_q    <= '0;
      done_q      <= 1'b0;
      rst_cpu_n_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      sync_q      <= sync_d;
      dly_q       <= dly_d;
      state_q     <= state_d;
      rem_q       <= rem_d;
      clk_en_q    <= clk_en_d;
      done_q      <= done_d;
      rst_cpu_n_q <= rst_cpu_n_d;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign clk_en    = clk_en_q;
  assign done      = done_q;
  assign rst_cpu_n = rst_cpu_n_q;
  assign run_state = state_q;

endmodule

// File: tb/tb_cpu_clken_gen.sv
// Randomized scoreboard bench for cpu_clken_gen against an arithmetic reference model
// of the enable channels, run control and lock sequencer.
module tb_cpu_clken_gen;

  localparam int          NUM_CH      = 2;
  localparam int          ACC_W       = 24;
  localparam int          BURST_W     = 16;
  localparam int unsigned GATED_MASK  = 1;
  localparam int          SYNC_STAGES = 3;
  localparam int          RESET_DELAY = 16;
  localparam int          START_RUN   = 1;
  localparam int          OW          = NUM_CH + 6;
  localparam logic [NUM_CH-1:0] GATED = GATED_MASK[NUM_CH-1:0];

  logic                    clk_cpu_fast = 1'b0;
  logic                    rst_n;
  logic                    pll_locked;
  logic [NUM_CH*ACC_W-1:0] ch_inc;
  logic                    cmd_valid;
  logic [1:0]              cmd_mode;
  logic [BURST_W-1:0]      cmd_count;
  logic                    cmd_ready;
  logic [NUM_CH-1:0]       clk_en;
  logic                    rst_cpu_n;
  logic                    done;
  logic [2:0]              run_state;

  cpu_clken_gen #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .BURST_W(BURST_W), .GATED_MASK(GATED_MASK),
    .SYNC_STAGES(SYNC_STAGES), .RESET_DELAY(RESET_DELAY), .START_RUN(START_RUN)
  ) dut (
    .clk_cpu_fast(clk_cpu_fast), .rst_n(rst_n), .pll_locked(pll_locked),
    .ch_inc(ch_inc), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
    .cmd_count(cmd_count), .cmd_ready(cmd_ready), .clk_en(clk_en),
    .rst_cpu_n(rst_cpu_n), .done(done), .run_state(run_state)
  );

  always #10 clk_cpu_fast = ~clk_cpu_fast;

  // Reference model state: states use the output encoding 0..4
  int                errors = 0;
  int                checks = 0;
  int                m_state, m_rem, m_lock_edges;
  longint            m_acc [NUM_CH];
  bit                m_sync [$];
  logic [NUM_CH-1:0] m_en;
  bit                m_done, m_rst;
  logic [ACC_W-1:0]  inc_v [NUM_CH];
  logic [OW-1:0]     exp_q [$];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rem = 0; m_lock_edges = 0;
    m_en = '0; m_done = 0; m_rst = 0;
    foreach (m_acc[i]) m_acc[i] = 0;
    m_sync.delete();
    repeat (SYNC_STAGES) m_sync.push_back(1'b0);
  endtask

  task automatic model_edge(input bit pll, input bit cv, input logic [1:0] mode, input int cnt);
    bit     s, accepted, gated_run;
    int     nxt;
    longint sum;
    longint modulus = longint'(1) << ACC_W;
    s = m_sync.pop_front();
    m_sync.push_back(pll);
    accepted = cv && (m_state != 0);
    m_done = 0;
    m_en   = '0;
    if (!s) begin
      m_state = 0; m_rem = 0; m_lock_edges = 0; m_rst = 0;
      foreach (m_acc[i]) m_acc[i] = 0;
      return;
    end
    gated_run = (m_state == 2) || (m_state == 3) || (m_state == 4);
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_state != 0 && (!GATED[i] || gated_run)) begin
        sum      = m_acc[i] + longint'(inc_v[i]);
        m_en[i]  = (sum >= modulus);
        m_acc[i] = sum % modulus;
      end
    end
    nxt = m_state;
    if (m_state == 0) begin
      m_lock_edges++;
      if (m_lock_edges == RESET_DELAY) begin
        nxt   = (START_RUN != 0) ? 2 : 1;
        m_rst = 1;
      end
    end else begin
      if ((m_state == 3 || m_state == 4) && m_en[0]) begin
        if (m_rem == 1) begin
          m_done = 1;
          nxt    = 1;
        end else begin
          m_rem--;
        end
      end
      if (accepted) begin
        case (mode)
          2'd0: nxt = 2;
          2'd1: nxt = 1;
          2'd2: begin nxt = 3; m_rem = 1; end
          default: begin
            if (cnt == 0) begin nxt = 1; m_done = 1; end
            else begin nxt = 4; m_rem = cnt; end
          end
        endcase
      end
    end
    m_state = nxt;
  endtask

  task automatic apply_stimulus(input bit pll, input bit cv, input logic [1:0] mode, input int cnt);
    @(negedge clk_cpu_fast);
    #1;
    pll_locked = pll;
    cmd_valid  = cv;
    cmd_mode   = mode;
    cmd_count  = BURST_W'(cnt);
    for (int i = 0; i < NUM_CH; i++) ch_inc[i*ACC_W +: ACC_W] = inc_v[i];
    model_edge(pll, cv, mode, cnt);
    exp_q.push_back({m_en, m_done, m_rst, 3'(m_state), (m_state != 0)});
    @(posedge clk_cpu_fast);
  endtask

  task automatic run_count(input bit pll, input int n, output int p0, output int dn);
    p0 = 0;
    dn = 0;
    repeat (n) begin
      apply_stimulus(pll, 1'b0, 2'd0, 0);
      #1;
      p0 += int'(clk_en[0]);
      dn += int'(done);
    end
  endtask

  task automatic relock_measure(input string name);
    int rel = 0;
    for (int e = 1; e <= 40; e++) begin
      apply_stimulus(1'b1, 1'b0, 2'd0, 0);
      #1;
      if (rel == 0 && rst_cpu_n) rel = e;
    end
    check_output(name, rel, SYNC_STAGES + RESET_DELAY);
    check_output({name, "_state"}, run_state, 2);
    check_output({name, "_ready"}, cmd_ready, 1);
  endtask

  // Monitor: every cycle the DUT presents a new output set, compared against the scoreboard
  always @(negedge clk_cpu_fast) begin
    logic [OW-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {clk_en, done, rst_cpu_n, run_state, cmd_ready};
      checks++;
      if (a !== e) begin
        errors++;
        $display("[TB] FAIL outputs t=%0t actual en=%b done=%b rst=%b st=%0d rdy=%b required en=%b done=%b rst=%b st=%0d rdy=%b",
                 $time, a[OW-1:6], a[5], a[4], a[3:1], a[0], e[OW-1:6], e[5], e[4], e[3:1], e[0]);
      end
    end
  end

  initial begin
    int p0, dn, d0, drop, c;
    bit cv;
    logic [1:0] mode;
    int cnt;

    rst_n = 1'b0; pll_locked = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0;
    cmd_count = '0; ch_inc = '0;
    foreach (inc_v[i]) inc_v[i] = '0;
    model_reset();
    repeat (2) @(negedge clk_cpu_fast);
    check_output("reset_state", {clk_en, done, rst_cpu_n, run_state, cmd_ready}, 0);
    #1 rst_n = 1'b1;

    $display("[TB] lock sequence and RUN pulse rate");
    inc_v[0] = 24'h800000;
    inc_v[1] = 24'h100000;
    relock_measure("release_edge");
    run_count(1'b1, 1000, p0, dn);
    check_output("run_500_pulses", p0, 500);

    $display("[TB] HALT then BURST 5");
    inc_v[0] = 24'h400000;
    apply_stimulus(1'b1, 1'b1, 2'd1, 0);
    run_count(1'b1, 5, p0, dn);
    check_output("halt_no_pulses", p0, 0);
    apply_stimulus(1'b1, 1'b1, 2'd3, 5);
    run_count(1'b1, 40, p0, dn);
    check_output("burst5_pulses", p0, 5);
    check_output("burst5_done", dn, 1);
    check_output("burst5_halt", run_state, 1);

    $display("[TB] STEP and zero-length BURST");
    apply_stimulus(1'b1, 1'b1, 2'd2, 0);
    run_count(1'b1, 20, p0, dn);
    check_output("step_pulses", p0, 1);
    check_output("step_done", dn, 1);
    apply_stimulus(1'b1, 1'b1, 2'd3, 0);
    #1 d0 = int'(done);
    check_output("burst0_done", d0, 1);
    run_count(1'b1, 10, p0, dn);
    check_output("burst0_no_pulses", p0 + dn, 0);

    $display("[TB] lock loss mid-BURST");
    apply_stimulus(1'b1, 1'b1, 2'd3, 100);
    run_count(1'b1, 10, p0, dn);
    run_count(1'b0, 6, p0, dn);
    check_output("loss_no_done", dn, 0);
    check_output("loss_rst_cpu", rst_cpu_n, 0);
    check_output("loss_state", run_state, 0);
    relock_measure("relock_edge");

    $display("[TB] randomized traffic");
    drop = 0;
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) begin
        c = $urandom_range(0, NUM_CH - 1);
        case ($urandom_range(0, 3))
          0:       inc_v[c] = '0;
          1:       inc_v[c] = 24'h800000;
          default: inc_v[c] = ACC_W'($urandom);
        endcase
      end
      if (drop == 0 && $urandom_range(0, 399) == 0) drop = $urandom_range(1, 8);
      cv   = ($urandom_range(0, 9) == 0);
      mode = 2'($urandom_range(0, 3));
      cnt  = $urandom_range(0, 6);
      apply_stimulus(drop == 0, cv, mode, cnt);
      if (drop > 0) drop--;
    end

    $display("[TB] asynchronous reset during RUN");
    run_count(1'b1, 30, p0, dn);
    apply_stimulus(1'b1, 1'b1, 2'd0, 0);
    run_count(1'b1, 10, p0, dn);
    @(negedge clk_cpu_fast);
    #2;
    pll_locked = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", {clk_en, done, rst_cpu_n, run_state, cmd_ready}, 0);
    model_reset();
    @(negedge clk_cpu_fast);
    #2 rst_n = 1'b1;
    relock_measure("release_after_rst");
    run_count(1'b1, 50, p0, dn);

    @(negedge clk_cpu_fast);
    #2;
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
